// File: rtl/screen_sequencer_pkg.sv
// Shared encodings for the screen sequencer and the full-screen drawer:
// screen IDs, game modes, sequencer FSM states and the per-cycle request bundle.
package screen_sequencer_pkg;

   localparam logic [1:0] SCR_MAP1  = 2'd0;
   localparam logic [1:0] SCR_MAP2  = 2'd1;
   localparam logic [1:0] SCR_START = 2'd2;

   typedef enum logic [1:0] {
      MODE_TITLE = 2'd0,
      MODE_GAME  = 2'd1,
      MODE_PAUSE = 2'd2
   } mode_t;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_DRAW  = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   // One-cycle requests after priority resolution (start > pause > anim).
   typedef struct packed {
      logic start;
      logic pause;
      logic anim;
   } req_t;

   function automatic logic [1:0] toggle_map(input logic [1:0] m);
      return (m == SCR_MAP1) ? SCR_MAP2 : SCR_MAP1;
   endfunction

endpackage

// File: rtl/screen_sequencer_key_edge_sync.sv
// Two-flop synchronizer for a raw active-low key, followed by a falling-edge
// detector that emits a single-cycle press pulse per key-down.
module key_edge_sync (
   input  logic clock,
   input  logic resetn,
   input  logic key_n,
   output logic press
);

   logic meta, sync, sync_d;

   // Flops reset to the released level so a reset never fakes a press.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         meta   <= 1'b1;
         sync   <= 1'b1;
         sync_d <= 1'b1;
      end else begin
         meta   <= key_n;
         sync   <= meta;
         sync_d <= sync;
      end
   end

   assign press = sync_d & ~sync;

endmodule

// File: rtl/screen_sequencer.sv
// Sequencer in front of the full-screen drawer: tracks title/game/pause mode,
// animates the game map, and runs the drawer's enable/done handshake.
module screen_sequencer
   import screen_sequencer_pkg::*;
#(
   parameter int CLKS_PER_FRAME = 833333,
   parameter int ANIM_FRAMES    = 15,
   parameter int DRAW_TIMEOUT   = 19210
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       start_n,
   input  logic       pause_n,
   input  logic       drawScreenDone,
   output logic [1:0] ScreenSelect,
   output logic       drawScreenEnable,
   output logic       plot,
   output logic       busy,
   output logic       frame_tick,
   output logic [7:0] frames_drawn,
   output logic       draw_error
);

   localparam int FW = (CLKS_PER_FRAME > 1) ? $clog2(CLKS_PER_FRAME) : 1;
   localparam int AW = (ANIM_FRAMES    > 1) ? $clog2(ANIM_FRAMES)    : 1;
   localparam int TW = (DRAW_TIMEOUT   > 1) ? $clog2(DRAW_TIMEOUT)   : 1;

   state_t         state, next_state;
   mode_t          mode;
   logic [1:0]     map_sel;
   logic [FW-1:0]  frame_cnt;
   logic [AW-1:0]  anim_cnt;
   logic [TW-1:0]  draw_cnt;
   logic           pending;
   logic [1:0]     key_n, key_press;
   req_t           req;
   logic           anim_wrap, redraw_req;
   logic           launch, done_hit, timeout;

   assign key_n = {pause_n, start_n};

   for (genvar i = 0; i < 2; i++) begin : g_key
      key_edge_sync u_sync (
         .clock  (clock),
         .resetn (resetn),
         .key_n  (key_n[i]),
         .press  (key_press[i])
      );
   end

   assign frame_tick = (frame_cnt == FW'(CLKS_PER_FRAME - 1));
   assign anim_wrap  = frame_tick && (mode == MODE_GAME) && (anim_cnt == AW'(ANIM_FRAMES - 1));

   // A pause in the same cycle swallows the animation step.
   assign req.start  = key_press[0];
   assign req.pause  = key_press[1] && !key_press[0];
   assign req.anim   = anim_wrap && !key_press[0] && !key_press[1];
   assign redraw_req = req.start || (req.pause && (mode != MODE_TITLE)) || req.anim;

   always_ff @(posedge clock) begin
      if (!resetn) frame_cnt <= '0;
      else if (frame_tick) frame_cnt <= '0;
      else frame_cnt <= frame_cnt + FW'(1);
   end

   always_ff @(posedge clock) begin
      if (!resetn) anim_cnt <= '0;
      else if (req.start) anim_cnt <= '0;
      else if (frame_tick && (mode == MODE_GAME)) anim_cnt <= anim_wrap ? '0 : anim_cnt + AW'(1);
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         mode    <= MODE_TITLE;
         map_sel <= SCR_MAP1;
      end else if (req.start) begin
         mode <= (mode == MODE_TITLE) ? MODE_GAME : MODE_TITLE;
         if (mode == MODE_TITLE) map_sel <= SCR_MAP1;
      end else if (req.pause) begin
         if (mode == MODE_GAME)       mode <= MODE_PAUSE;
         else if (mode == MODE_PAUSE) mode <= MODE_GAME;
      end else if (req.anim) begin
         map_sel <= toggle_map(map_sel);
      end
   end

   // New requests win over the launch clear so nothing is ever dropped.
   always_ff @(posedge clock) begin
      if (!resetn) pending <= 1'b0;
      else if (redraw_req || timeout) pending <= 1'b1;
      else if (launch) pending <= 1'b0;
   end

   always_ff @(posedge clock) begin
      if (!resetn) state <= ST_INIT;
      else state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_INIT:  next_state = ST_DRAW;
         ST_IDLE:  if (pending) next_state = ST_DRAW;
         ST_DRAW:  if (drawScreenDone || timeout) next_state = ST_CLEAR;
         ST_CLEAR: next_state = ST_IDLE;
         default:  next_state = ST_INIT;
      endcase
   end

   always_comb begin
      drawScreenEnable = 1'b0;
      busy             = 1'b0;
      launch           = 1'b0;
      done_hit         = 1'b0;
      timeout          = 1'b0;
      case (state)
         ST_IDLE:  launch = pending;
         ST_DRAW: begin
            drawScreenEnable = 1'b1;
            busy             = 1'b1;
            done_hit         = drawScreenDone;
            timeout          = !drawScreenDone && (draw_cnt == TW'(DRAW_TIMEOUT - 1));
         end
         ST_CLEAR: busy = 1'b1;
         default: ;
      endcase
   end

   // plot trails enable by one cycle (drawer pixels are registered) but drops with it.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         ScreenSelect <= SCR_START;
         plot         <= 1'b0;
         frames_drawn <= '0;
         draw_error   <= 1'b0;
         draw_cnt     <= '0;
      end else begin
         plot     <= (state == ST_DRAW) && (next_state == ST_DRAW);
         draw_cnt <= (state == ST_DRAW) ? draw_cnt + TW'(1) : '0;
         if (state == ST_INIT) ScreenSelect <= SCR_START;
         else if (launch) ScreenSelect <= (mode == MODE_TITLE) ? SCR_START : map_sel;
         if (done_hit) frames_drawn <= frames_drawn + 8'd1;
         if (timeout) draw_error <= 1'b1;
      end
   end

endmodule

// File: tb/tb_screen_sequencer.sv
// Scoreboarded bench: each key action queues the screen IDs it should cause,
// and a monitor pops one entry per drawer-enable rising edge.
module tb_screen_sequencer;

   localparam int CPF      = 16;
   localparam int AF       = 3;
   localparam int DT       = 40;
   localparam int DONE_LAT = 20;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       start_n = 1'b1;
   logic       pause_n = 1'b1;
   logic       drawScreenDone = 1'b0;
   logic [1:0] ScreenSelect;
   logic       drawScreenEnable, plot, busy, frame_tick, draw_error;
   logic [7:0] frames_drawn;

   always #5 clock = ~clock;

   screen_sequencer #(
      .CLKS_PER_FRAME (CPF),
      .ANIM_FRAMES    (AF),
      .DRAW_TIMEOUT   (DT)
   ) dut (
      .clock            (clock),
      .resetn           (resetn),
      .start_n          (start_n),
      .pause_n          (pause_n),
      .drawScreenDone   (drawScreenDone),
      .ScreenSelect     (ScreenSelect),
      .drawScreenEnable (drawScreenEnable),
      .plot             (plot),
      .busy             (busy),
      .frame_tick       (frame_tick),
      .frames_drawn     (frames_drawn),
      .draw_error       (draw_error)
   );

   // Drawer model: done goes high DONE_LAT cycles after enable, unless hung.
   logic hang = 1'b0;
   int   dcnt = 0;
   always @(posedge clock) begin
      if (!resetn || !drawScreenEnable) begin
         dcnt           <= 0;
         drawScreenDone <= 1'b0;
      end else begin
         dcnt           <= dcnt + 1;
         drawScreenDone <= !hang && (dcnt >= DONE_LAT - 1);
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   logic [1:0] exp_q[$];
   int   cyc = 0, rise_cnt = 0, fall_cnt = 0, tick_cnt = 0;
   int   last_rise = 0, last_fall = 0, last_tick = 0;

   // Monitor: one scoreboard pop per draw start, stability checks per draw.
   initial begin
      logic       prev_en, sel_moved, plot_bad;
      logic [1:0] sel_at_rise;
      prev_en = 1'b0; sel_moved = 1'b0; plot_bad = 1'b0; sel_at_rise = 2'd0;
      forever begin
         @(negedge clock);
         cyc++;
         if (frame_tick === 1'b1) begin
            tick_cnt++;
            last_tick = cyc;
         end
         if (drawScreenEnable === 1'b1 && !prev_en) begin
            rise_cnt++;
            last_rise   = cyc;
            sel_at_rise = ScreenSelect;
            sel_moved   = 1'b0;
            plot_bad    = (plot !== 1'b0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected draw: select %0d at cycle %0d, none queued", ScreenSelect, cyc);
            end else begin
               chk($sformatf("draw %0d select", rise_cnt), 32'(ScreenSelect), 32'(exp_q.pop_front()));
            end
         end else if (drawScreenEnable === 1'b1 && prev_en) begin
            if (ScreenSelect !== sel_at_rise) sel_moved = 1'b1;
            if (plot !== 1'b1) plot_bad = 1'b1;
         end else if (drawScreenEnable !== 1'b1 && prev_en) begin
            fall_cnt++;
            last_fall = cyc;
            chk($sformatf("draw %0d select stable", fall_cnt), 32'(sel_moved), 32'd0);
            chk($sformatf("draw %0d plot trails enable", fall_cnt), 32'(plot_bad | (plot !== 1'b0)), 32'd0);
         end
         prev_en = (drawScreenEnable === 1'b1);
      end
   end

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   task automatic press_start();
      start_n = 1'b0;
      repeat (5) step();
      start_n = 1'b1;
   endtask

   task automatic press_pause();
      pause_n = 1'b0;
      repeat (5) step();
      pause_n = 1'b1;
   endtask

   task automatic wait_fall(input int target, input int budget, input string name);
      int n = 0;
      while (fall_cnt < target && n < budget) begin step(); n++; end
      if (fall_cnt < target) begin
         n_checks++; n_fail++;
         $display("FAIL %s: draw end count %0d, expected %0d within %0d cycles", name, fall_cnt, target, budget);
      end
   endtask

   task automatic wait_tick(input string name);
      int t0 = tick_cnt;
      int n  = 0;
      while (tick_cnt == t0 && n < 3 * CPF) begin step(); n++; end
      if (tick_cnt == t0) begin
         n_checks++; n_fail++;
         $display("FAIL %s: frame_tick count %0d, expected %0d", name, tick_cnt, t0 + 1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int a, b_fall, f9;

      // Reset state
      resetn = 1'b0;
      repeat (3) step();
      chk("reset ScreenSelect", 32'(ScreenSelect), 32'd2);
      chk("reset enable", 32'(drawScreenEnable), 32'd0);
      chk("reset plot", 32'(plot), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset frame_tick", 32'(frame_tick), 32'd0);
      chk("reset frames_drawn", 32'(frames_drawn), 32'd0);
      chk("reset draw_error", 32'(draw_error), 32'd0);

      // Title drawn once after reset
      exp_q.push_back(2'd2);
      resetn = 1'b1;
      step();
      chk("title enable after reset", 32'(drawScreenEnable), 32'd1);
      wait_fall(1, 60, "title draw");
      chk("title enable length", 32'(last_fall - last_rise), 32'(DONE_LAT + 1));
      chk("frames after title", 32'(frames_drawn), 32'd1);
      chk("busy in clear", 32'(busy), 32'd1);
      step();
      chk("busy after clear", 32'(busy), 32'd0);
      wait_tick("tick a");
      a = last_tick;
      wait_tick("tick b");
      chk("frame tick period", 32'(last_tick - a), 32'(CPF));

      // Start -> MAP1, then two animation toggles
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd0);
      press_start();
      wait_fall(4, 400, "game draws");
      chk("frames after game toggles", 32'(frames_drawn), 32'd4);

      // Pause aligned to a tick, then hold still for 10 ticks
      wait_tick("pre-pause tick");
      exp_q.push_back(2'd0);
      press_pause();
      wait_fall(5, 100, "pause draw");
      chk("frames after pause", 32'(frames_drawn), 32'd5);
      for (int i = 0; i < 10; i++) wait_tick("paused tick");
      chk("frames frozen in pause", 32'(frames_drawn), 32'd5);
      chk("no draws in pause", 32'(rise_cnt), 32'd5);

      // Resume; the next tick toggles the map mid-draw
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd1);
      press_pause();
      wait_fall(6, 100, "resume draw");
      b_fall = last_fall;
      wait_fall(7, 100, "latched anim draw");
      chk("gap after latched anim", 32'(last_rise - b_fall), 32'd2);
      chk("frames after resume", 32'(frames_drawn), 32'd7);

      // Pause again, then start back to title with a hung drawer
      exp_q.push_back(2'd1);
      press_pause();
      wait_fall(8, 100, "second pause draw");
      hang = 1'b1;
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd2);
      press_start();
      wait_fall(9, 200, "timeout draw");
      f9 = last_fall;
      chk("timeout enable length", 32'(last_fall - last_rise), 32'(DT));
      chk("draw_error after timeout", 32'(draw_error), 32'd1);
      chk("frames unchanged by timeout", 32'(frames_drawn), 32'd8);
      hang = 1'b0;
      wait_fall(10, 100, "retry draw");
      chk("retry gap", 32'(last_rise - f9), 32'd2);
      chk("frames after retry", 32'(frames_drawn), 32'd9);

      // Reset in the middle of a GAME draw
      exp_q.push_back(2'd0);
      press_start();
      chk("game draw in progress", 32'(drawScreenEnable), 32'd1);
      repeat (3) step();
      resetn = 1'b0;
      step();
      chk("mid-draw reset enable", 32'(drawScreenEnable), 32'd0);
      chk("mid-draw reset plot", 32'(plot), 32'd0);
      chk("mid-draw reset frames", 32'(frames_drawn), 32'd0);
      chk("mid-draw reset select", 32'(ScreenSelect), 32'd2);
      chk("mid-draw reset error", 32'(draw_error), 32'd0);
      exp_q.push_back(2'd2);
      step();
      resetn = 1'b1;
      wait_fall(12, 100, "title redraw after reset");
      chk("frames after reset redraw", 32'(frames_drawn), 32'd1);
      repeat (4) step();
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
